// File: rtl/sc_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module : sc_fifo_pkg
// Brief  : Shared constants and helpers for the sc_fifo_ctrl slice.
// Rev    : 1.0 - initial release
// ============================================================================
package sc_fifo_pkg;

  localparam int C_DEFAULT_DATA_WIDTH   = 32;
  localparam int C_DEFAULT_BUFFER_DEPTH = 8;
  localparam int C_MAX_DEPTH            = 1024;

  typedef logic [C_MAX_DEPTH-1:0] ring_vec_t;

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Rotate-left-by-one of a one-hot ring whose live width is 'depth'.
  function automatic ring_vec_t onehot_rotl(input ring_vec_t v, input int depth);
    ring_vec_t r;
    r    = v << 1;
    r[0] = v[10'(depth - 1)];
    if (depth < C_MAX_DEPTH) begin
      r[10'(depth)] = 1'b0;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sc_fifo_ctrl_onehot_ring_ptr.sv
`default_nettype none
// ============================================================================
// Module : onehot_ring_ptr
// Brief  : One-hot ring pointer; advances one slot left per adv pulse.
// Rev    : 1.0 - initial release
// ============================================================================
module onehot_ring_ptr
  import sc_fifo_pkg::*;
#(
  parameter int DEPTH = C_DEFAULT_BUFFER_DEPTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             adv,
  output logic [DEPTH-1:0] ptr
);

  logic [DEPTH-1:0] r_ptr;
  logic [DEPTH-1:0] w_next;
  ring_vec_t        w_cur;
  ring_vec_t        w_rot;
  logic             w_unused;

  always_comb begin
    w_cur            = '0;
    w_cur[DEPTH-1:0] = r_ptr;
    w_rot            = onehot_rotl(w_cur, DEPTH);
    w_next           = w_rot[DEPTH-1:0];
  end

  // Upper bits of the wide helper result are always zero.
  assign w_unused = ^w_rot;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr <= {{(DEPTH-1){1'b0}}, 1'b1};
    end else if (adv) begin
      r_ptr <= w_next;
    end
  end

  assign ptr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/sc_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module : sc_fifo_ctrl
// Brief  : Single-clock FIFO controller driving an external slot buffer
//          through one-hot write/read pointers. Define SC_FIFO_CTRL_THRESH_EN
//          to add registered almost_full/almost_empty flags.
// Rev    : 1.0 - initial release
// ============================================================================
module sc_fifo_ctrl
  import sc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = C_DEFAULT_DATA_WIDTH,
  parameter int BUFFER_DEPTH = C_DEFAULT_BUFFER_DEPTH
`ifdef SC_FIFO_CTRL_THRESH_EN
  ,
  parameter int AFULL_LVL    = BUFFER_DEPTH - 1,
  parameter int AEMPTY_LVL   = 1
`endif
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [DATA_WIDTH-1:0]                 in_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [DATA_WIDTH-1:0]                 out_data,
  output logic [BUFFER_DEPTH-1:0]               write_pointer,
  output logic [DATA_WIDTH-1:0]                 write_data,
  output logic [BUFFER_DEPTH-1:0]               read_pointer,
  input  logic [DATA_WIDTH-1:0]                 read_data,
  output logic [count_width(BUFFER_DEPTH)-1:0]  count
`ifdef SC_FIFO_CTRL_THRESH_EN
  ,
  output logic                                  almost_full,
  output logic                                  almost_empty
`endif
);

  localparam int             CNT_W   = count_width(BUFFER_DEPTH);
  localparam logic [CNT_W-1:0] c_depth = CNT_W'(BUFFER_DEPTH);
  localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_next;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  assign w_full    = (r_count == c_depth);
  assign in_ready  = !w_full;
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  // The buffer is written every cycle; when full, rewrite the head with itself.
  assign write_data = w_full ? read_data : in_data;
  assign out_data   = read_data;

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + c_one;
    end else if (w_pop && !w_push) begin
      w_count_next = r_count - c_one;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign count = r_count;

  onehot_ring_ptr #(.DEPTH(BUFFER_DEPTH)) u_wr_ptr (
    .clk  (clk),
    .rstn (rstn),
    .adv  (w_push),
    .ptr  (write_pointer)
  );

  onehot_ring_ptr #(.DEPTH(BUFFER_DEPTH)) u_rd_ptr (
    .clk  (clk),
    .rstn (rstn),
    .adv  (w_pop),
    .ptr  (read_pointer)
  );

`ifdef SC_FIFO_CTRL_THRESH_EN
  localparam logic [CNT_W-1:0] c_afull  = CNT_W'(AFULL_LVL);
  localparam logic [CNT_W-1:0] c_aempty = CNT_W'(AEMPTY_LVL);

  logic r_almost_full;
  logic r_almost_empty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else begin
      r_almost_full  <= (w_count_next >= c_afull);
      r_almost_empty <= (w_count_next <= c_aempty);
    end
  end

  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sc_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_sc_fifo_ctrl
// Brief  : Self-checking bench for sc_fifo_ctrl with an external slot buffer
//          and a queue-based reference model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_sc_fifo_ctrl;

  localparam int DW    = 32;
  localparam int DEPTH = 8;

  logic          clk;
  logic          rstn;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [DEPTH-1:0] write_pointer;
  logic [DW-1:0] write_data;
  logic [DEPTH-1:0] read_pointer;
  logic [DW-1:0] read_data;
  logic [3:0]    count;
`ifdef SC_FIFO_CTRL_THRESH_EN
  logic          almost_full;
  logic          almost_empty;
`endif

  sc_fifo_ctrl #(.DATA_WIDTH(DW), .BUFFER_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .write_pointer (write_pointer),
    .write_data    (write_data),
    .read_pointer  (read_pointer),
    .read_data     (read_data),
    .count         (count)
`ifdef SC_FIFO_CTRL_THRESH_EN
    ,
    .almost_full   (almost_full),
    .almost_empty  (almost_empty)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External slot buffer: written every cycle at the one-hot write slot.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (write_pointer[i]) mem[i] <= write_data;
    end
  end
  always_comb begin
    read_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (read_pointer[i]) read_data = mem[i];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] q[$];
  int wp = 0;
  int rp = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    logic [7:0] one;
    one = 8'h01;
    chk("count", 64'(count), 64'(q.size()));
    chk("in_ready", 64'(in_ready), 64'(q.size() != DEPTH));
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("write_pointer", 64'(write_pointer), 64'(one << wp));
    chk("read_pointer", 64'(read_pointer), 64'(one << rp));
`ifdef SC_FIFO_CTRL_THRESH_EN
    chk("almost_full", 64'(almost_full), 64'(q.size() >= DEPTH - 1));
    chk("almost_empty", 64'(almost_empty), 64'(q.size() <= 1));
`endif
  endtask

  // One clock: drive, check, advance model across the rising edge.
  task automatic cycle(input logic iv, input logic [DW-1:0] id, input logic ordy);
    logic push;
    logic pop;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    #1;
    check_state();
    if (q.size() != 0) chk("out_data", 64'(out_data), 64'(q[0]));
    chk("write_data", 64'(write_data), 64'((q.size() == DEPTH) ? q[0] : id));
    push = iv && (q.size() < DEPTH);
    pop  = ordy && (q.size() > 0);
    @(posedge clk);
    if (pop) begin
      void'(q.pop_front());
      rp = (rp + 1) % DEPTH;
    end
    if (push) begin
      q.push_back(id);
      wp = (wp + 1) % DEPTH;
    end
    @(negedge clk);
  endtask

  task automatic fill_to(input int n);
    while (q.size() < n) cycle(1'b1, DW'($urandom), 1'b0);
  endtask

  task automatic drain();
    while (q.size() > 0) cycle(1'b0, '0, 1'b1);
  endtask

  initial begin
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    rstn      = 1'b1;
    #1 rstn   = 1'b0;
    #1;
    check_state();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // Fill with A0..A7, then read them back in order.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(32'hA0 + i), 1'b0);
    #1;
    chk("full_count", 64'(count), 64'(DEPTH));
    chk("full_in_ready", 64'(in_ready), 64'(0));
    chk("full_wp_eq_rp", 64'(write_pointer), 64'(read_pointer));
    for (int i = 0; i < DEPTH; i++) begin
      chk("ordered_pop", 64'(out_data), 64'(32'hA0 + i));
      cycle(1'b0, '0, 1'b1);
    end
    chk("empty_count", 64'(count), 64'(0));

    // Steady simultaneous push/pop at occupancy 3 across pointer wrap.
    fill_to(3);
    for (int i = 0; i < 20; i++) cycle(1'b1, DW'($urandom), 1'b1);
    #1 chk("steady_count", 64'(count), 64'(3));
    drain();

    // Full with a pushing producer: head must survive, pop reopens in_ready.
    fill_to(DEPTH);
    for (int i = 0; i < 3; i++) cycle(1'b1, DW'(32'hDEAD), 1'b0);
    cycle(1'b1, DW'(32'hDEAD), 1'b1);
    #1;
    chk("pop_from_full_ready", 64'(in_ready), 64'(1));
    chk("pop_from_full_count", 64'(count), 64'(DEPTH - 1));
    drain();

    // Asynchronous reset mid-transfer at occupancy 5.
    fill_to(5);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #2 rstn   = 1'b0;
    #1;
    q.delete();
    wp = 0;
    rp = 0;
    check_state();
    @(posedge clk);
    #1 check_state();
    @(negedge clk);
    rstn = 1'b1;

    // Randomized traffic: push-heavy, then pop-heavy, then balanced.
    for (int i = 0; i < 450; i++) begin
      int bias;
      bias = (i < 150) ? 75 : (i < 300) ? 25 : 50;
      cycle(1'($urandom_range(0, 99) < bias), DW'($urandom),
            1'($urandom_range(0, 99) >= bias));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sc_fifo_ctrl.md
SC_FIFO_CTRL -- requirements
Module: sc_fifo_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the payload width in bits.
REQ-002 The block SHALL have parameter BUFFER_DEPTH, default 8, giving the number of buffer slots (legal range 2..1024).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the producer offers in_data.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the controller accepts in_data.
REQ-007 The block SHALL have port in_data, input, DATA_WIDTH bits: the producer payload.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the head entry is available.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer takes the head entry.
REQ-010 The block SHALL have port out_data, output, DATA_WIDTH bits: the head payload.
REQ-011 The block SHALL have port write_pointer, output, BUFFER_DEPTH bits: one-hot write slot driven to the data buffer.
REQ-012 The block SHALL have port write_data, output, DATA_WIDTH bits: data driven to the data buffer.
REQ-013 The block SHALL have port read_pointer, output, BUFFER_DEPTH bits: one-hot read slot driven to the data buffer.
REQ-014 The block SHALL have port read_data, input, DATA_WIDTH bits: the buffer content at read_pointer.
REQ-015 The block SHALL have port count, output, clog2(BUFFER_DEPTH+1) bits: the current occupancy.

Function
REQ-016 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-017 in_ready SHALL equal (count != BUFFER_DEPTH); out_valid SHALL equal (count != 0); both SHALL be combinational from state only.
REQ-018 On push, write_pointer SHALL rotate left by one bit, with the MSB wrapping to bit 0; on pop, read_pointer SHALL rotate the same way.
REQ-019 The data buffer writes every cycle, so write_data SHALL equal in_data when not full and SHALL equal read_data when full, preserving the head slot.
REQ-020 out_data SHALL equal read_data combinationally; zero-latency fall-through is not provided, so a pushed entry SHALL become visible on the cycle after the push.
REQ-021 count SHALL increment on push only, decrement on pop only, and hold on simultaneous push and pop.
REQ-022 Simultaneous push and pop at 0 < count < BUFFER_DEPTH SHALL be accepted in the same cycle, and both pointers SHALL advance.
REQ-023 At count == BUFFER_DEPTH, write_pointer SHALL equal read_pointer; a pop in that cycle SHALL drop count to BUFFER_DEPTH-1, and in_ready SHALL rise the next cycle.
REQ-024 Both pointers SHALL remain strictly one-hot at all times.

Reset
REQ-025 While rstn is low: write_pointer = read_pointer = 1 (bit 0 set), count = 0, in_ready = 1, out_valid = 0.
REQ-026 Reset asserted mid-transfer SHALL discard all entries immediately, with no pending push or pop completing.

Configuration
REQ-027 With SC_FIFO_CTRL_THRESH_EN defined, the block SHALL add parameters AFULL_LVL (default BUFFER_DEPTH-1) and AEMPTY_LVL (default 1), plus registered outputs almost_full = (next count >= AFULL_LVL) and almost_empty = (next count <= AEMPTY_LVL).
REQ-028 almost_full SHALL reset to 0 and almost_empty SHALL reset to 1.
REQ-029 Without SC_FIFO_CTRL_THRESH_EN, those parameters and ports SHALL be absent and the remaining behaviour SHALL be unchanged.

Structure
REQ-030 The shared package sc_fifo_pkg SHALL hold the count-width function, the one-hot rotate function and the default DATA_WIDTH/BUFFER_DEPTH constants.
REQ-031 The one-hot pointer SHALL be a sub-module, onehot_ring_ptr (ports clk, rstn, adv, ptr), instantiated twice; the data buffer itself SHALL be external.

Verification
REQ-032 Reset -> write_pointer = read_pointer = 8'h01, count = 0, in_ready = 1, out_valid = 0.
REQ-033 Push 8 words 0xA0..0xA7, no pops -> count = 8, in_ready = 0, write_pointer = 8'h01, write_data follows read_data; then pop 8 -> out_data = 0xA0..0xA7 in order, count = 0.
REQ-034 Continuous push and pop at count = 3 for 20 cycles -> count stays 3, data order preserved across pointer wrap.
REQ-035 Full, with in_valid = 1 and in_data = 0xDEAD -> head slot unchanged; pop -> in_ready = 1 the next cycle, count = 7.
REQ-036 rstn pulsed low at count = 5 -> count = 0 asynchronously, pointers = 8'h01, and no stale out_valid.
REQ-037 With SC_FIFO_CTRL_THRESH_EN, defaults, depth 8 -> almost_full = 1 at count 7, almost_empty = 1 at count <= 1.
